// File: rtl/lcm_pkg.sv
// lcm_pkg: scheduler state encoding and default operand width / watchdog limit
package lcm_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT, RESP} sched_state_t;
  localparam int LCM_W = 8;
  localparam int LCM_TMO = 1023;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority pick of req from ptr (clk, rst, req, adv -> gnt one-hot, idx, any); adv moves ptr past idx
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] ptr;
  logic [IW:0] s;
  always_comb begin
    idx = '0;
    s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW + 1)'(k);
      s = (s >= (IW + 1)'(NREQ)) ? s - (IW + 1)'(NREQ) : s;
      idx = req[s[IW-1:0]] ? s[IW-1:0] : idx;
    end
    any = |req;
    gnt = any ? NREQ'(1) << idx : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (adv) ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
endmodule

// File: rtl/lcm_job_scheduler.sv
// lcm_job_scheduler: round-robin sharing of one LCM core (req_* in, core_* to core, resp_* out tagged with requester id)
module lcm_job_scheduler import lcm_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W = LCM_W,
  parameter int TMO = LCM_TMO,
  localparam int IW = $clog2(NREQ),
  localparam int WDW = $clog2(TMO + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]    core_a,
  output logic [W-1:0]    core_b,
  output logic            core_proceed,
  input  logic            core_done,
  input  logic [2*W-1:0]  core_result,
  output logic            core_abort,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IW-1:0]   resp_id,
  output logic [2*W-1:0]  resp_result,
  output logic            resp_err
);
  sched_state_t state;
  logic [WDW-1:0] wdog;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] idx;
  logic any;
  logic [W-1:0] ga, gb;
  logic tmo;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .adv(state == GRANT && any),
    .gnt(gnt), .idx(idx), .any(any)
  );
  always_comb begin
    ga = W'(req_a >> (idx * W));
    gb = W'(req_b >> (idx * W));
    tmo = wdog == WDW'(TMO);
    req_ready = (state == GRANT) ? gnt : '0;
    core_proceed = state == LAUNCH;
    core_abort = state == WAIT && !core_done && tmo;
    resp_valid = state == RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      core_a <= '0;
      core_b <= '0;
      resp_id <= '0;
      resp_result <= '0;
      resp_err <= 1'b0;
      wdog <= '0;
    end else
      case (state)
        IDLE: state <= any ? GRANT : IDLE;
        GRANT:
          if (any) begin
            core_a <= ga;
            core_b <= gb;
            resp_id <= idx;
            resp_result <= '0;
            resp_err <= 1'b0;
            state <= (ga == '0 || gb == '0) ? RESP : LAUNCH;
          end else state <= IDLE;
        LAUNCH: begin
          wdog <= '0;
          state <= WAIT;
        end
        WAIT:
          if (core_done) begin
            resp_result <= core_result;
            state <= RESP;
          end else if (tmo) begin
            resp_err <= 1'b1;
            state <= RESP;
          end else wdog <= wdog + WDW'(1);
        RESP: if (resp_ready) state <= any ? GRANT : IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_lcm_job_scheduler.sv
// tb_lcm_job_scheduler: scoreboard bench pairing the scheduler with a behavioural LCM core and stall/tie stub modes
module tb_lcm_job_scheduler;
  logic clk, rst;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0] core_a, core_b;
  logic core_proceed, core_done, core_abort;
  logic [15:0] core_result, resp_result;
  logic resp_valid, resp_ready, resp_err;
  logic [1:0] resp_id;
  int n_chk = 0, n_fail = 0;
  int stub;
  typedef struct {logic [1:0] id; logic [15:0] res; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  lcm_job_scheduler #(.NREQ(4), .W(8), .TMO(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .core_a(core_a), .core_b(core_b),
    .core_proceed(core_proceed), .core_done(core_done), .core_result(core_result),
    .core_abort(core_abort), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  logic busy;
  logic [15:0] x, y;
  int cnt;
  always @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 0;
      core_done <= 0;
      core_result <= 0;
      cnt <= 0;
    end else begin
      core_done <= 0;
      if (core_abort) busy <= 0;
      else if (core_proceed) begin
        busy <= 1;
        x <= {8'h0, core_a};
        y <= {8'h0, core_b};
        cnt <= 1;
      end else if (busy) begin
        cnt <= cnt + 1;
        if (stub == 0) begin
          if (x == y) begin
            core_done <= 1;
            core_result <= x;
            busy <= 0;
          end else if (x < y) x <= x + {8'h0, core_a};
          else y <= y + {8'h0, core_b};
        end else if (stub == 2 && cnt == 15) begin
          core_done <= 1;
          core_result <= 16'hbeef;
          busy <= 0;
        end
      end
    end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) check("resp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("resp_id", resp_id, e.id);
        check("resp_result", resp_result, e.res);
        check("resp_err", resp_err, e.err);
      end
    end
  function automatic logic [41:0] outs();
    return {req_ready, core_a, core_b, core_proceed, core_abort, resp_valid, resp_id, resp_result, resp_err};
  endfunction
  task automatic set(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask
  task automatic push(input logic [1:0] id, input logic [15:0] res, input logic err);
    sb.push_back('{id, res, err});
  endtask
  task automatic wait_grant(input logic [3:0] exp, input string nm);
    int n = 0;
    @(negedge clk);
    while (req_ready == 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(nm, req_ready, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(nm, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic seen;
    clk = 0; rst = 1; req_valid = 0; req_a = 0; req_b = 0; resp_ready = 1; stub = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst = 0;
    @(negedge clk);
    check("idle_outs", outs(), 0);
    @(posedge clk);
    #1;
    set(0, 3, 5); set(1, 4, 6); set(2, 2, 7); set(3, 6, 9);
    req_valid = 4'hf;
    push(0, 15, 0); push(1, 12, 0); push(2, 14, 0); push(3, 18, 0); push(0, 5, 0);
    wait_grant(4'b0001, "rr_g0"); set(0, 5, 5);
    wait_grant(4'b0010, "rr_g1"); req_valid[1] = 0;
    wait_grant(4'b0100, "rr_g2"); req_valid[2] = 0;
    wait_grant(4'b1000, "rr_g3"); req_valid[3] = 0;
    wait_grant(4'b0001, "rr_g4"); req_valid[0] = 0;
    drain("rr_drain");
    set(0, 4, 6);
    req_valid = 4'b0001;
    push(0, 12, 0);
    n = 0;
    @(negedge clk);
    while (!core_proceed && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t1_proceed_latency", n, 2);
    @(posedge clk);
    #1;
    req_valid = 0;
    drain("t1_drain");
    set(2, 0, 9);
    req_valid = 4'b0100;
    push(2, 0, 0);
    wait_grant(4'b0100, "t3_grant");
    req_valid = 0;
    @(negedge clk);
    check("t3_resp_no_launch", {resp_valid, core_proceed}, 2'b10);
    drain("t3_drain");
    resp_ready = 0;
    set(1, 7, 3);
    req_valid = 4'b0010;
    push(1, 21, 0); push(3, 6, 0);
    wait_grant(4'b0010, "t5_grant");
    req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    set(3, 2, 3);
    req_valid = 4'b1000;
    repeat (10) begin
      @(negedge clk);
      check("t5_hold", {resp_valid, resp_id, resp_result, resp_err, req_ready}, {1'b1, 2'd1, 16'd21, 1'b0, 4'b0});
    end
    @(posedge clk);
    #1;
    resp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("t5_next_grant", req_ready, 4'b1000);
    @(posedge clk);
    #1;
    req_valid = 0;
    drain("t5_drain");
    stub = 1;
    set(0, 5, 7);
    req_valid = 4'b0001;
    push(0, 0, 1);
    wait_grant(4'b0001, "t4_grant");
    req_valid = 0;
    @(negedge clk);
    check("t4_launch", core_proceed, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_abort && n < 40);
    check("t4_abort_latency", n, 16);
    check("t4_abort_excl", {core_abort, core_proceed}, 2'b10);
    drain("t4_drain");
    stub = 2;
    set(1, 5, 7);
    req_valid = 4'b0010;
    push(1, 16'hbeef, 0);
    wait_grant(4'b0010, "tie_grant");
    req_valid = 0;
    n = 0;
    seen = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      seen = seen | core_abort;
      n++;
    end
    check("tie_no_abort", seen, 0);
    drain("tie_drain");
    stub = 1;
    set(2, 4, 6);
    req_valid = 4'b0100;
    wait_grant(4'b0100, "t6_grant");
    req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("t6_rst_outs", outs(), 0);
    @(posedge clk);
    #1;
    rst = 0;
    stub = 0;
    set(0, 4, 6); set(3, 3, 5);
    req_valid = 4'b1001;
    push(0, 12, 0); push(3, 15, 0);
    wait_grant(4'b0001, "t6_first");
    req_valid[0] = 0;
    wait_grant(4'b1000, "t6_second");
    req_valid[3] = 0;
    drain("t6_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
